count_seq: RTL and testbench
============================

COUNT_SEQ -- requirements
Module: count_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 8, counter datapath width.
REQ-002 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req  input  2  per-requester level request, held until own done/err.
REQ-005 SHALL have ports: start_val0, end_val0, start_val1, end_val1  input  WIDTH  per-requester count window.
REQ-006 SHALL have port: abort  input  1  cancel current sequence.
REQ-007 SHALL have port: gnt  output  2  one-hot grant, held for whole sequence.
REQ-008 SHALL have ports: done, err  output  2  one-cycle completion and error pulses, per requester.
REQ-009 SHALL have port: busy  output  1  high in any non-IDLE state.
REQ-010 SHALL have ports: cnt_load  output  1, cnt_enable  output  1, cnt_data  output  WIDTH  drive the shared up-counter's load, enable and data_in.
REQ-011 SHALL have port: cnt_value  input  WIDTH  counter's current count.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, RUN, DONE, ERR.
- IDLE: any req -> LOAD.
- LOAD: -> RUN.
- RUN: cnt_value==end -> DONE; abort -> ERR.
- DONE, ERR: -> IDLE.
REQ-013 SHALL arbitrate round-robin in IDLE: on a single request, grant it; when both request, grant the one not granted last.
REQ-014 SHALL latch the granted requester's start_val/end_val into internal registers on the grant cycle; later input changes are ignored until the next grant.
REQ-015 SHALL assert gnt from the cycle after arbitration through the DONE/ERR cycle inclusive.
REQ-016 SHALL, in LOAD, drive cnt_load=1, cnt_enable=0, cnt_data=latched start for exactly one cycle.
REQ-017 SHALL, in RUN, drive cnt_enable=1 combinationally only while cnt_value != latched end, so the counter stops exactly on end.
REQ-018 SHALL pulse done[g] for one cycle in DONE; with D=(end-start) mod 2^WIDTH, done SHALL assert D+3 cycles after the arbitration cycle.
REQ-019 SHALL handle start==end as zero increments: one RUN cycle, then done.
REQ-020 SHALL, on abort in LOAD or RUN, deassert cnt_enable/cnt_load that cycle, enter ERR and pulse err[g].
REQ-021 SHALL give match priority over abort when both occur in the same RUN cycle (done, not err).
REQ-022 SHALL drive cnt_load=0 and cnt_enable=0 in all states other than LOAD and RUN.
REQ-023 SHALL re-arbitrate a requester that still holds req after its done/err pulse on the next IDLE cycle.

Reset
REQ-024 SHALL, on rst, force state=IDLE and gnt, done, err, busy, cnt_load, cnt_enable and cnt_data to 0, and set the round-robin pointer to favour req[0].
REQ-025 SHALL treat reset mid-sequence as immediate abandonment, with no done/err pulse; rst has priority over all other inputs.

Configuration
REQ-026 SHALL support macro COUNT_SEQ_WRAP_EN.
- Defined: end<start is legal and counting wraps through 2^WIDTH-1 -> 0.
- Undefined: end<start detected at grant skips LOAD, goes to ERR, pulses err[g] the next cycle and never asserts cnt_load/cnt_enable.

Structure
REQ-027 SHALL take the state enum, WIDTH default and requester-index type from package count_seq_pkg.
REQ-028 SHALL place the 2-way round-robin arbiter, with its pointer, in sub-module rr_arb2.

Verification
REQ-029 Bench SHALL pair count_seq with a reference 8-bit load/enable counter and cover:
- req0 start=10 end=14 -> one cnt_load cycle with cnt_data=10; cnt_value 10..14; done[0] 7 cycles after the arbitration cycle; count holds 14.
- req0 and req1 simultaneous after reset -> gnt=01 first; gnt=10 after done[0]; then req0 again wins while req1 holds.
- start=5 end=5 -> no cnt_enable cycles; done 3 cycles after arbitration.
- start=250 end=3: with WRAP_EN, count passes 255->0 and done after D=9, i.e. 12 cycles; without it, err pulse and no cnt_load.
- abort at count 20 (start=16 end=40) -> err[g] pulse, counter frozen at 20; abort on the match cycle -> done, not err.
- rst asserted during RUN -> next cycle all outputs 0, IDLE, no done/err.

Source files
------------

// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared types for the count sequencer.
// Holds the FSM state enum, the default datapath width and the
// requester-index type used by count_seq and rr_arb2.
package count_seq_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int N_REQ     = 2;

    typedef logic [0:0] req_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // One-hot grant vector for a requester index.
    function automatic logic [N_REQ-1:0] idx_onehot(input req_idx_t idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/count_seq_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Grant is combinational from the request vector; the pointer remembers
// the last winner and only moves when the caller accepts the grant.
// After reset the pointer favours requester 0.
module rr_arb2
    import count_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_valid,
    output req_idx_t   o_idx,
    output logic [1:0] o_gnt
);

    req_idx_t r_last;
    req_idx_t w_idx;

    // Pick the winner: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        w_idx = 1'b0;
        case (i_req)
            2'b01:   w_idx = 1'b0;
            2'b10:   w_idx = 1'b1;
            2'b11:   w_idx = ~r_last;
            default: w_idx = 1'b0;
        endcase
    end

    assign o_valid = |i_req;
    assign o_idx   = w_idx;
    assign o_gnt   = o_valid ? idx_onehot(w_idx) : 2'b00;

    // Pointer update on an accepted grant; reset makes requester 0 the tie winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_accept && o_valid) begin
            r_last <= w_idx;
        end
    end

endmodule

// File: rtl/count_seq.sv
// count_seq: sequences a shared load/enable up-counter for two requesters.
// A granted requester's start/end window is latched at arbitration; the
// counter is loaded with start, enabled until it reads end, then a done
// pulse is issued. Abort ends the sequence with an err pulse.
//
// Build option COUNT_SEQ_WRAP_EN:
//   defined   - end < start is legal, the count wraps through zero.
//   undefined - end < start is rejected at grant: straight to ERR, the
//               counter is never loaded or enabled.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no sequence; arbitrate pending requests
// LOAD  | one cycle: counter loaded with latched start
// RUN   | counter enabled until it reaches latched end (or abort)
// DONE  | one cycle: done pulse to the granted requester
// ERR   | one cycle: err pulse to the granted requester
module count_seq
    import count_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] start_val0,
    input  logic [WIDTH-1:0] end_val0,
    input  logic [WIDTH-1:0] start_val1,
    input  logic [WIDTH-1:0] end_val1,
    input  logic             abort,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [1:0]       err,
    output logic             busy,
    output logic             cnt_load,
    output logic             cnt_enable,
    output logic [WIDTH-1:0] cnt_data,
    input  logic [WIDTH-1:0] cnt_value
);

    state_t           r_state;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_end;
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic [1:0]       r_err;
    logic             r_busy;

    logic             w_arb_valid;
    req_idx_t         w_arb_idx;
    logic [1:0]       w_arb_gnt;
    logic             w_arb_accept;
    logic [WIDTH-1:0] w_sel_start;
    logic [WIDTH-1:0] w_sel_end;
    logic             w_bad_window;
    logic             w_match;

    assign w_arb_accept = (r_state == ST_IDLE);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (req),
        .i_accept (w_arb_accept),
        .o_valid  (w_arb_valid),
        .o_idx    (w_arb_idx),
        .o_gnt    (w_arb_gnt)
    );

    assign w_sel_start = w_arb_idx ? start_val1 : start_val0;
    assign w_sel_end   = w_arb_idx ? end_val1   : end_val0;

`ifdef COUNT_SEQ_WRAP_EN
    assign w_bad_window = 1'b0;
`else
    assign w_bad_window = (w_sel_end < w_sel_start);
`endif

    assign w_match = (cnt_value == r_end);

    // Sequencer FSM: next state, latched window and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_start <= '0;
            r_end   <= '0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_err   <= 2'b00;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 2'b00;
            r_err  <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_start <= w_sel_start;
                        r_end   <= w_sel_end;
                        r_gnt   <= w_arb_gnt;
                        r_busy  <= 1'b1;
                        if (w_bad_window) begin
                            r_state <= ST_ERR;
                            r_err   <= w_arb_gnt;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        r_state <= ST_ERR;
                        r_err   <= r_gnt;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A match wins over a simultaneous abort.
                    if (w_match) begin
                        r_state <= ST_DONE;
                        r_done  <= r_gnt;
                    end else if (abort) begin
                        r_state <= ST_ERR;
                        r_err   <= r_gnt;
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign err  = r_err;
    assign busy = r_busy;

    // Counter controls react to abort/reset in the same cycle so the count freezes at once.
    assign cnt_load   = (r_state == ST_LOAD) && !abort && !rst;
    assign cnt_enable = (r_state == ST_RUN) && !w_match && !abort && !rst;
    assign cnt_data   = (r_state == ST_LOAD) ? r_start : '0;

endmodule

// File: tb/tb_count_seq.sv
// tb_count_seq: count_seq paired with an 8-bit load/enable counter.
// A cycle-offset model (outputs as a function of cycles since arbitration)
// is compared with the DUT every cycle; directed scenarios pin the model
// with literal latencies and counter values, then random traffic follows.
// Build option COUNT_SEQ_WRAP_EN changes the end<start expectations.
module tb_count_seq;
    import count_seq_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] sv0, ev0, sv1, ev1;
    logic         abort;
    logic [1:0]   gnt, done, err;
    logic         busy, cnt_load, cnt_enable;
    logic [W-1:0] cnt_data, cnt_value;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .start_val0 (sv0),
        .end_val0   (ev0),
        .start_val1 (sv1),
        .end_val1   (ev1),
        .abort      (abort),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .cnt_load   (cnt_load),
        .cnt_enable (cnt_enable),
        .cnt_data   (cnt_data),
        .cnt_value  (cnt_value)
    );

    logic [W-1:0] ref_cnt;
    always @(posedge clk) begin
        if (rst)             ref_cnt <= '0;
        else if (cnt_load)   ref_cnt <= cnt_data;
        else if (cnt_enable) ref_cnt <= ref_cnt + 8'd1;
    end
    assign cnt_value = ref_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh(input int g);
        return (g == 1) ? 2'b10 : 2'b01;
    endfunction

    // ---------------- behavioural model ----------------
    // m_k counts cycles since the arbitration cycle; m_end_k is the cycle
    // of the done/err pulse once known (0 = not yet decided).
    bit           m_valid = 1'b0;
    bit           m_act   = 1'b0;
    int           m_k, m_end_k, m_g;
    bit           m_end_done, m_last, m_bad;
    logic [W-1:0] m_s, m_e, m_cnt, m_cnt_cur;
    logic         e_in_load, e_in_run, e_load, e_en;
    logic [1:0]   e_gnt, e_done, e_err;

    always @(negedge clk) begin
        if (m_valid) begin
            e_in_load = m_act && (m_k == 1) && (m_end_k != 1);
            e_in_run  = m_act && (m_k >= 2) && (m_k != m_end_k);
            e_load    = e_in_load && !abort && !rst;
            e_en      = e_in_run && (m_cnt != m_e) && !abort && !rst;
            e_gnt     = m_act ? oh(m_g) : 2'b00;
            e_done    = (m_act && m_k == m_end_k && m_end_done)  ? oh(m_g) : 2'b00;
            e_err     = (m_act && m_k == m_end_k && !m_end_done) ? oh(m_g) : 2'b00;
            chk("gnt",        32'(gnt),        32'(e_gnt));
            chk("busy",       32'(busy),       32'(m_act));
            chk("done",       32'(done),       32'(e_done));
            chk("err",        32'(err),        32'(e_err));
            chk("cnt_load",   32'(cnt_load),   32'(e_load));
            chk("cnt_enable", 32'(cnt_enable), 32'(e_en));
            chk("cnt_value",  32'(cnt_value),  32'(m_cnt));
            if (e_load) chk("cnt_data", 32'(cnt_data), 32'(m_s));
        end
        if (rst) begin
            m_act   = 1'b0;
            m_last  = 1'b1;
            m_cnt   = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_cnt_cur = m_cnt;
            if (e_load)    m_cnt = m_s;
            else if (e_en) m_cnt = m_cnt + 8'd1;
            if (m_act) begin
                if (m_k == m_end_k) begin
                    m_act = 1'b0;
                end else begin
                    if (m_end_k == 0) begin
                        if (m_k == 1) begin
                            if (abort) begin m_end_k = 2; m_end_done = 1'b0; end
                        end else if (m_cnt_cur == m_e) begin
                            m_end_k = m_k + 1; m_end_done = 1'b1;
                        end else if (abort) begin
                            m_end_k = m_k + 1; m_end_done = 1'b0;
                        end
                    end
                    m_k++;
                end
            end else if (req != 2'b00) begin
                if (req == 2'b11) m_g = m_last ? 0 : 1;
                else              m_g = req[1] ? 1 : 0;
                m_last = (m_g == 1);
                m_s    = (m_g == 1) ? sv1 : sv0;
                m_e    = (m_g == 1) ? ev1 : ev0;
`ifdef COUNT_SEQ_WRAP_EN
                m_bad  = 1'b0;
`else
                m_bad  = (m_e < m_s);
`endif
                m_act      = 1'b1;
                m_k        = 1;
                m_end_k    = m_bad ? 1 : 0;
                m_end_done = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 2'b00; abort = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int c = 0;
        while (busy !== 1'b0 && c < maxc) begin cyc(); c++; end
        if (busy !== 1'b0) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy=%b expected 0", busy);
        end
    endtask

    task automatic wait_gnt(input int maxc);
        int c = 0;
        while (gnt == 2'b00 && c < maxc) begin cyc(); c++; end
        if (gnt == 2'b00) begin
            checks++; errors++;
            $display("FAIL gnt_timeout: gnt=%b expected nonzero", gnt);
        end
    endtask

    task automatic wait_end(input int idx, input int maxc);
        int c = 0;
        do begin cyc(); c++; end while (!(done[idx] || err[idx]) && c < maxc);
        if (!(done[idx] || err[idx])) begin
            checks++; errors++;
            $display("FAIL end_timeout: req%0d got no done/err expected one", idx);
        end
    endtask

    // Raise one request, return cycles from arbitration to done/err.
    task automatic run_one(input int idx, input logic [W-1:0] s, input logic [W-1:0] e,
                           input int maxc, output int n, output bit got_err);
        wait_idle(20);
        if (idx == 0) begin sv0 = s; ev0 = e; end
        else          begin sv1 = s; ev1 = e; end
        req[idx] = 1'b1;
        n = -1; got_err = 1'b0;
        for (int c = 1; c <= maxc; c++) begin
            cyc();
            if (c == 1) begin sv0 = W'($urandom); ev0 = W'($urandom); sv1 = W'($urandom); ev1 = W'($urandom); end
            if (done[idx] || err[idx]) begin
                n = c; got_err = err[idx]; req[idx] = 1'b0;
                break;
            end
        end
        if (n < 0) begin
            checks++; errors++;
            $display("FAIL run_timeout: req%0d no done/err within %0d", idx, maxc);
            req[idx] = 1'b0;
        end
    endtask

    int n;
    bit ge;
    logic [W-1:0] rs;

    initial begin
        rst = 1'b1; req = 2'b00; abort = 1'b0;
        sv0 = '0; ev0 = '0; sv1 = '0; ev1 = '0;
        do_reset();

        chk("rst_gnt",  32'(gnt),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_load", 32'(cnt_load), 32'd0);
        chk("rst_data", 32'(cnt_data), 32'd0);

        // 10 -> 14: D=4, done 7 cycles after arbitration, count holds at 14.
        run_one(0, 8'd10, 8'd14, 50, n, ge);
        chk("s1_latency", 32'(n), 32'd7);
        chk("s1_is_done", 32'(ge), 32'd0);
        cyc(); cyc(); cyc();
        chk("s1_hold", 32'(cnt_value), 32'd14);

        // Simultaneous requests after reset: 0, then 1, then 0 again.
        do_reset();
        sv0 = 8'd1; ev0 = 8'd3; sv1 = 8'd7; ev1 = 8'd8;
        req = 2'b11;
        cyc();
        chk("s2_first_gnt", 32'(gnt), 32'd1);
        wait_end(0, 50);
        chk("s2_done0", 32'(done[0]), 32'd1);
        req[0] = 1'b0;
        cyc();
        wait_gnt(10);
        chk("s2_second_gnt", 32'(gnt), 32'd2);
        req[0] = 1'b1;
        wait_end(1, 50);
        chk("s2_done1", 32'(done[1]), 32'd1);
        cyc();
        wait_gnt(10);
        chk("s2_third_gnt", 32'(gnt), 32'd1);
        wait_end(0, 50);
        req = 2'b00;
        wait_idle(10);

        // start == end: no enable cycles, done 3 cycles after arbitration.
        run_one(1, 8'd5, 8'd5, 50, n, ge);
        chk("s3_latency", 32'(n), 32'd3);
        chk("s3_is_done", 32'(ge), 32'd0);

        // 250 -> 3: wraps (D=9, 12 cycles) or is rejected at grant.
        run_one(0, 8'd250, 8'd3, 50, n, ge);
`ifdef COUNT_SEQ_WRAP_EN
        chk("s4_latency", 32'(n), 32'd12);
        chk("s4_is_done", 32'(ge), 32'd0);
        cyc(); cyc();
        chk("s4_hold", 32'(cnt_value), 32'd3);
`else
        chk("s4_latency", 32'(n), 32'd1);
        chk("s4_is_err", 32'(ge), 32'd1);
        cyc(); cyc();
        chk("s4_untouched", 32'(cnt_value), 32'd5);
`endif

        // Abort at count 20 in a 16 -> 40 window.
        wait_idle(20);
        sv0 = 8'd16; ev0 = 8'd40; req[0] = 1'b1;
        for (int c = 0; c < 60 && !(busy && cnt_value == 8'd20); c++) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("s5_err",  32'(err),  32'd1);
        chk("s5_done", 32'(done), 32'd0);
        req[0] = 1'b0;
        cyc(); cyc();
        chk("s5_frozen", 32'(cnt_value), 32'd20);

        // Abort on the match cycle: done wins.
        wait_idle(20);
        sv1 = 8'd30; ev1 = 8'd33; req[1] = 1'b1;
        for (int c = 0; c < 60 && !(busy && cnt_value == 8'd33); c++) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("s5b_done", 32'(done), 32'd2);
        chk("s5b_err",  32'(err),  32'd0);
        req[1] = 1'b0;

        // Reset during RUN: everything drops on the next cycle.
        wait_idle(20);
        sv0 = 8'd0; ev0 = 8'd100; req[0] = 1'b1;
        repeat (6) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; req = 2'b00;
        chk("s6_gnt",  32'(gnt),  32'd0);
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_done", 32'(done), 32'd0);
        chk("s6_err",  32'(err),  32'd0);
        chk("s6_load", 32'(cnt_load),   32'd0);
        chk("s6_en",   32'(cnt_enable), 32'd0);
        chk("s6_data", 32'(cnt_data),   32'd0);
        repeat (3) cyc();

        // Random traffic; requesters hold req until their own done/err.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1; req = 2'b00; abort = 1'b0;
            end else begin
                rst = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    if (req[i]) begin
                        if ((done[i] || err[i]) && $urandom_range(0, 1) == 0) req[i] = 1'b0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                    end
                end
                abort = ($urandom_range(0, 24) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    rs  = W'($urandom);
                    sv0 = rs;
                    ev0 = ($urandom_range(0, 4) == 0) ? rs - W'($urandom_range(1, 6)) : rs + W'($urandom_range(0, 12));
                    rs  = W'($urandom);
                    sv1 = rs;
                    ev1 = ($urandom_range(0, 4) == 0) ? rs - W'($urandom_range(1, 6)) : rs + W'($urandom_range(0, 12));
                end
            end
            cyc();
        end
        rst = 1'b0; abort = 1'b0; req = 2'b00;
        repeat (300) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
